gaussian_mem_responder: RTL and testbench
=========================================

// Module: gaussian_mem_responder
// PURPOSE
//  Memory-side responder for the gaussian kernel datapath's load/store ports: serves word-addressed
//  reads on A (ports a, b) and c, and writes on A (port a), with fixed registered read latency.
//  Sits between the kernel datapath/controller and on-chip RAM; a host port preloads/dumps arrays.
// PARAMETERS
//  A_AW 8 : A word-address width (A depth = 2**A_AW)
//  C_AW 4 : c word-address width (c depth = 2**C_AW)
//  DW 32 : data width
//  RD_LAT 1 : read latency in cycles, legal 1..4
//  STORE_FIELD_SWAP 1 : 1 = store address arrives on toMem[A_AW-1:0], data on addr (zero-extended)
//  CNT_W 16 : width of saturating access counters
// PORTS
//  clk  in  1  clock
//  rst  in  1  synchronous active-high reset
//  loaddd_A_a_0_en / _addr  in  1 / A_AW  port-a read strobe, word address
//  loaddd_A_a_0_fromMem  out  DW  port-a read data
//  loaddd_A_b_0_en / _addr  in  1 / A_AW  port-b read strobe, word address
//  loaddd_A_b_0_fromMem  out  DW  port-b read data
//  loaddd_c_a_0_en / _addr  in  1 / C_AW  c read strobe, word address
//  loaddd_c_a_0_fromMem  out  DW  c read data
//  storeee_A_a_0_en  in  1  A write strobe
//  storeee_A_a_0_addr  in  A_AW  store field (see STORE_FIELD_SWAP)
//  storeee_A_a_0_toMem  in  DW  store field (see STORE_FIELD_SWAP)
//  host_en / host_we / host_sel  in  1/1/1  host request, write, array select (0=A, 1=c)
//  host_addr / host_wdata  in  A_AW / DW  host word address (c uses low C_AW bits), write data
//  host_ready  out  1  host may transfer this cycle
//  host_rvalid / host_rdata  out  1 / DW  host read response
//  load_cnt / store_cnt  out  CNT_W  saturating counts of accepted kernel loads / stores
// BEHAVIOUR
//  - Reset: all fromMem outputs, host_rdata, host_rvalid, load/store_cnt = 0; read pipelines cleared.
//    RAM contents are not reset.
//  - Kernel read: en high at cycle t -> data on fromMem at t+RD_LAT. Output holds last returned value
//    until the next read completes. Ports a, b, c are independent and may all fire in one cycle.
//  - Write: en high at t -> RAM updated at end of t. Same-cycle read of the same A address on a or b
//    returns the new data (write-first). A read at t+1 always sees the write.
//  - STORE_FIELD_SWAP=1: waddr = toMem[A_AW-1:0], wdata = {{(DW-A_AW){1'b0}}, addr}.
//    STORE_FIELD_SWAP=0: waddr = addr, wdata = toMem.
//  - Host: host_ready = ~(any kernel en). Transfer occurs iff host_en & host_ready. Kernel always wins;
//    a host request with ready low is ignored (host must hold and retry). Host read -> host_rvalid
//    pulses 1 cycle at t+RD_LAT with host_rdata; host write follows kernel write timing.
//  - Counters: load_cnt += number of kernel read strobes (0..3) per cycle, store_cnt += store strobe;
//    both saturate at 2**CNT_W-1, never wrap.
//  - Reset mid-operation: in-flight reads are discarded, no fromMem update or rvalid after rst.
//  - Address wrap: none. Addresses are full-width indices. Host c access ignores host_addr[A_AW-1:C_AW].
// STRUCTURE
//  - Shared package gaussian_mem_pkg: DW, A_AW, C_AW, RD_LAT_MAX=4, host_sel encodings.
//  - One sub-module gaussian_rd_pipe (valid + data shift of depth RD_LAT with hold register),
//    instantiated per read port (a, b, c, host). RAM arrays and arbitration live in the top.
// TESTING
//  - Reset: assert rst 2 cycles mid-traffic -> all outputs 0, no fromMem change for RD_LAT after release.
//  - Host preload A[5]=0x1234, c[3]=7; kernel reads a@5, b@5, c@3 same cycle -> at t+RD_LAT a=b=0x1234, c=7.
//  - SWAP=1 store toMem=0x2A, addr=0x9C with a-read @0x2A same cycle -> fromMem_a=0x0000009C.
//  - Host read while any kernel en high -> host_ready=0, no rvalid; released -> rvalid once, correct data.
//  - Run with RD_LAT=1 and RD_LAT=4 -> data arrives exactly RD_LAT cycles after en; holds afterwards.
//  - CNT_W=4: issue 6 cycles of triple reads -> load_cnt = 15 (saturated), store_cnt unchanged.

Source files
------------

// File: rtl/gaussian_mem_pkg.sv
// Shared constants for the gaussian kernel memory responder: default widths,
// read-port indices and host array-select encoding.
package gaussian_mem_pkg;

    localparam int DW         = 32;
    localparam int A_AW       = 8;
    localparam int C_AW       = 4;
    localparam int RD_LAT_MAX = 4;

    // Read pipes, one per read port
    localparam int RD_A = 0;
    localparam int RD_B = 1;
    localparam int RD_C = 2;
    localparam int RD_H = 3;
    localparam int N_RD = 4;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_C = 1'b1
    } host_sel_e;

endpackage

// File: rtl/gaussian_mem_responder_if.sv
// Kernel load/store ports, host preload/dump port and access counters of the
// gaussian memory responder.
interface gaussian_mem_responder_if #(
    parameter int A_AW  = 8,
    parameter int C_AW  = 4,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             loaddd_A_a_0_en;
    logic [A_AW-1:0]  loaddd_A_a_0_addr;
    logic [DW-1:0]    loaddd_A_a_0_fromMem;
    logic             loaddd_A_b_0_en;
    logic [A_AW-1:0]  loaddd_A_b_0_addr;
    logic [DW-1:0]    loaddd_A_b_0_fromMem;
    logic             loaddd_c_a_0_en;
    logic [C_AW-1:0]  loaddd_c_a_0_addr;
    logic [DW-1:0]    loaddd_c_a_0_fromMem;
    logic             storeee_A_a_0_en;
    logic [A_AW-1:0]  storeee_A_a_0_addr;
    logic [DW-1:0]    storeee_A_a_0_toMem;

    logic             host_en;
    logic             host_we;
    logic             host_sel;
    logic [A_AW-1:0]  host_addr;
    logic [DW-1:0]    host_wdata;
    logic             host_ready;
    logic             host_rvalid;
    logic [DW-1:0]    host_rdata;

    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    modport master (
        output loaddd_A_a_0_en, loaddd_A_a_0_addr,
        output loaddd_A_b_0_en, loaddd_A_b_0_addr,
        output loaddd_c_a_0_en, loaddd_c_a_0_addr,
        output storeee_A_a_0_en, storeee_A_a_0_addr, storeee_A_a_0_toMem,
        output host_en, host_we, host_sel, host_addr, host_wdata,
        input  loaddd_A_a_0_fromMem, loaddd_A_b_0_fromMem, loaddd_c_a_0_fromMem,
        input  host_ready, host_rvalid, host_rdata, load_cnt, store_cnt
    );

    modport slave (
        input  loaddd_A_a_0_en, loaddd_A_a_0_addr,
        input  loaddd_A_b_0_en, loaddd_A_b_0_addr,
        input  loaddd_c_a_0_en, loaddd_c_a_0_addr,
        input  storeee_A_a_0_en, storeee_A_a_0_addr, storeee_A_a_0_toMem,
        input  host_en, host_we, host_sel, host_addr, host_wdata,
        output loaddd_A_a_0_fromMem, loaddd_A_b_0_fromMem, loaddd_c_a_0_fromMem,
        output host_ready, host_rvalid, host_rdata, load_cnt, store_cnt
    );

endinterface

// File: rtl/gaussian_rd_pipe.sv
// Extends a registered RAM read (latency 1) to RD_LAT cycles; every stage only
// loads on a valid beat, so the last stage doubles as the output hold register.
module gaussian_rd_pipe #(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [DW-1:0] ram_q,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);

    // vld_reg[i] marks a beat whose data sits i+1 cycles after its strobe
    logic vld_reg [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) vld_reg[i] <= 1'b0;
        end else begin
            vld_reg[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_reg[i] <= vld_reg[i-1];
        end
    end

    assign rd_valid = vld_reg[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
        // The RAM output register already loads only on a strobe and holds.
        assign rd_data = ram_q;
    end else begin : g_latn
        logic [DW-1:0] dat_reg [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT - 1; i++) dat_reg[i] <= '0;
            end else begin
                if (vld_reg[0]) dat_reg[0] <= ram_q;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    if (vld_reg[i]) dat_reg[i] <= dat_reg[i-1];
                end
            end
        end

        assign rd_data = dat_reg[RD_LAT-2];
    end

endmodule

// File: rtl/gaussian_mem_responder.sv
// Memory-side responder for the gaussian kernel: arrays A and c, kernel read/write
// ports with fixed read latency, a lower-priority host port and saturating counters.
module gaussian_mem_responder #(
    parameter int A_AW             = gaussian_mem_pkg::A_AW,
    parameter int C_AW             = gaussian_mem_pkg::C_AW,
    parameter int DW               = gaussian_mem_pkg::DW,
    parameter int RD_LAT           = 1,
    parameter int STORE_FIELD_SWAP = 1,
    parameter int CNT_W            = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    gaussian_mem_responder_if.slave  bus
);
    import gaussian_mem_pkg::*;

    logic [DW-1:0] mem_a [2**A_AW];
    logic [DW-1:0] mem_c [2**C_AW];

    logic            kern_any;
    logic            host_go;
    logic            host_rd;
    logic            a_we;
    logic            c_we;
    logic [A_AW-1:0] a_waddr;
    logic [DW-1:0]   a_wdata;
    logic [C_AW-1:0] host_c_addr;
    logic [A_AW-1:0] st_waddr;
    logic [DW-1:0]   st_wdata;

    logic [N_RD-1:0] rd_en;
    logic [DW-1:0]   ram_q    [N_RD];
    logic            pipe_vld [N_RD];
    logic [DW-1:0]   pipe_dat [N_RD];

    logic [CNT_W-1:0] load_cnt_reg;
    logic [CNT_W-1:0] store_cnt_reg;
    logic [CNT_W:0]   load_sum;
    logic [CNT_W:0]   store_sum;
    logic [1:0]       n_loads;

    // The generated store port carries its address and data fields crossed.
    if (STORE_FIELD_SWAP != 0) begin : g_swap
        assign st_waddr = bus.storeee_A_a_0_toMem[A_AW-1:0];
        assign st_wdata = {{(DW-A_AW){1'b0}}, bus.storeee_A_a_0_addr};
    end else begin : g_straight
        assign st_waddr = bus.storeee_A_a_0_addr;
        assign st_wdata = bus.storeee_A_a_0_toMem;
    end

    // Any kernel strobe blocks the host, so the A write port never has two sources.
    assign kern_any    = bus.loaddd_A_a_0_en | bus.loaddd_A_b_0_en
                       | bus.loaddd_c_a_0_en | bus.storeee_A_a_0_en;
    assign host_go     = bus.host_en & ~kern_any;
    assign host_rd     = host_go & ~bus.host_we;
    assign host_c_addr = bus.host_addr[C_AW-1:0];

    assign a_we    = bus.storeee_A_a_0_en | (host_go & bus.host_we & (bus.host_sel == SEL_A));
    assign c_we    = host_go & bus.host_we & (bus.host_sel == SEL_C);
    assign a_waddr = bus.storeee_A_a_0_en ? st_waddr : bus.host_addr;
    assign a_wdata = bus.storeee_A_a_0_en ? st_wdata : bus.host_wdata;

    always_ff @(posedge clk) begin
        if (a_we) mem_a[a_waddr] <= a_wdata;
        if (c_we) mem_c[host_c_addr] <= bus.host_wdata;
    end

    assign rd_en = {host_rd, bus.loaddd_c_a_0_en, bus.loaddd_A_b_0_en, bus.loaddd_A_a_0_en};

    // Registered reads, write-first on the kernel A ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RD; i++) ram_q[i] <= '0;
        end else begin
            if (rd_en[RD_A])
                ram_q[RD_A] <= (a_we && a_waddr == bus.loaddd_A_a_0_addr) ? a_wdata
                                                                          : mem_a[bus.loaddd_A_a_0_addr];
            if (rd_en[RD_B])
                ram_q[RD_B] <= (a_we && a_waddr == bus.loaddd_A_b_0_addr) ? a_wdata
                                                                          : mem_a[bus.loaddd_A_b_0_addr];
            if (rd_en[RD_C])
                ram_q[RD_C] <= mem_c[bus.loaddd_c_a_0_addr];
            if (rd_en[RD_H])
                ram_q[RD_H] <= (bus.host_sel == SEL_C) ? mem_c[host_c_addr] : mem_a[bus.host_addr];
        end
    end

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_pipe
        gaussian_rd_pipe #(
            .DW     (DW),
            .RD_LAT (RD_LAT)
        ) u_pipe (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[gi]),
            .ram_q    (ram_q[gi]),
            .rd_valid (pipe_vld[gi]),
            .rd_data  (pipe_dat[gi])
        );
    end

    assign bus.loaddd_A_a_0_fromMem = pipe_dat[RD_A];
    assign bus.loaddd_A_b_0_fromMem = pipe_dat[RD_B];
    assign bus.loaddd_c_a_0_fromMem = pipe_dat[RD_C];
    assign bus.host_rdata           = pipe_dat[RD_H];
    assign bus.host_rvalid          = pipe_vld[RD_H];
    assign bus.host_ready           = ~kern_any;

    // One spare sum bit catches overflow; at most +3 per cycle so clamping is exact.
    assign n_loads   = 2'(bus.loaddd_A_a_0_en) + 2'(bus.loaddd_A_b_0_en) + 2'(bus.loaddd_c_a_0_en);
    assign load_sum  = {1'b0, load_cnt_reg} + (CNT_W+1)'(n_loads);
    assign store_sum = {1'b0, store_cnt_reg} + (CNT_W+1)'(bus.storeee_A_a_0_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_reg  <= '0;
            store_cnt_reg <= '0;
        end else begin
            load_cnt_reg  <= load_sum[CNT_W]  ? '1 : load_sum[CNT_W-1:0];
            store_cnt_reg <= store_sum[CNT_W] ? '1 : store_sum[CNT_W-1:0];
        end
    end

    assign bus.load_cnt  = load_cnt_reg;
    assign bus.store_cnt = store_cnt_reg;

endmodule

// File: tb/tb_gaussian_mem_responder.sv
// Directed bench: two responders (RD_LAT=1 with 4-bit counters, RD_LAT=4 with
// 16-bit counters) share one stimulus stream and are checked against fixed vectors.
module tb_gaussian_mem_responder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    gaussian_mem_responder_if #(.A_AW(8), .C_AW(4), .DW(32), .CNT_W(4))  bus1 ();
    gaussian_mem_responder_if #(.A_AW(8), .C_AW(4), .DW(32), .CNT_W(16)) bus4 ();

    gaussian_mem_responder #(
        .A_AW(8), .C_AW(4), .DW(32), .RD_LAT(1), .STORE_FIELD_SWAP(1), .CNT_W(4)
    ) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    gaussian_mem_responder #(
        .A_AW(8), .C_AW(4), .DW(32), .RD_LAT(4), .STORE_FIELD_SWAP(1), .CNT_W(16)
    ) u_lat4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.loaddd_A_a_0_en     = bus1.loaddd_A_a_0_en;
    assign bus4.loaddd_A_a_0_addr   = bus1.loaddd_A_a_0_addr;
    assign bus4.loaddd_A_b_0_en     = bus1.loaddd_A_b_0_en;
    assign bus4.loaddd_A_b_0_addr   = bus1.loaddd_A_b_0_addr;
    assign bus4.loaddd_c_a_0_en     = bus1.loaddd_c_a_0_en;
    assign bus4.loaddd_c_a_0_addr   = bus1.loaddd_c_a_0_addr;
    assign bus4.storeee_A_a_0_en    = bus1.storeee_A_a_0_en;
    assign bus4.storeee_A_a_0_addr  = bus1.storeee_A_a_0_addr;
    assign bus4.storeee_A_a_0_toMem = bus1.storeee_A_a_0_toMem;
    assign bus4.host_en             = bus1.host_en;
    assign bus4.host_we             = bus1.host_we;
    assign bus4.host_sel            = bus1.host_sel;
    assign bus4.host_addr           = bus1.host_addr;
    assign bus4.host_wdata          = bus1.host_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.loaddd_A_a_0_en  = 1'b0;
        bus1.loaddd_A_b_0_en  = 1'b0;
        bus1.loaddd_c_a_0_en  = 1'b0;
        bus1.storeee_A_a_0_en = 1'b0;
        bus1.host_en          = 1'b0;
        bus1.host_we          = 1'b0;
    endtask

    task automatic host_wr(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        $display("txn host_wr sel=%0d addr=0x%02h data=0x%08h", sel, addr, data);
        bus1.host_en    = 1'b1;
        bus1.host_we    = 1'b1;
        bus1.host_sel   = sel;
        bus1.host_addr  = addr;
        bus1.host_wdata = data;
        #1;
        chk("host_ready_wr", 32'(bus1.host_ready), 32'd1);
        tick();
        idle();
    endtask

    // Host read issued at the next edge; rvalid must pulse at k=1 (lat1) and k=4 (lat4).
    task automatic host_rd(input logic sel, input logic [7:0] addr, input logic [31:0] exp);
        $display("txn host_rd sel=%0d addr=0x%02h expect=0x%08h", sel, addr, exp);
        bus1.host_en   = 1'b1;
        bus1.host_we   = 1'b0;
        bus1.host_sel  = sel;
        bus1.host_addr = addr;
        #1;
        chk("host_ready_rd", 32'(bus1.host_ready), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) idle();
            chk($sformatf("rvalid1_k%0d", k), 32'(bus1.host_rvalid), 32'(k == 1));
            chk($sformatf("rvalid4_k%0d", k), 32'(bus4.host_rvalid), 32'(k == 4));
            if (k == 1) chk("rdata1", bus1.host_rdata, exp);
            if (k == 4) chk("rdata4", bus4.host_rdata, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a1"},   bus1.loaddd_A_a_0_fromMem, 32'h0);
        chk({tag, "_b1"},   bus1.loaddd_A_b_0_fromMem, 32'h0);
        chk({tag, "_c1"},   bus1.loaddd_c_a_0_fromMem, 32'h0);
        chk({tag, "_rv1"},  32'(bus1.host_rvalid),     32'h0);
        chk({tag, "_rd1"},  bus1.host_rdata,           32'h0);
        chk({tag, "_ld1"},  32'(bus1.load_cnt),        32'h0);
        chk({tag, "_st1"},  32'(bus1.store_cnt),       32'h0);
        chk({tag, "_a4"},   bus4.loaddd_A_a_0_fromMem, 32'h0);
        chk({tag, "_b4"},   bus4.loaddd_A_b_0_fromMem, 32'h0);
        chk({tag, "_c4"},   bus4.loaddd_c_a_0_fromMem, 32'h0);
        chk({tag, "_rv4"},  32'(bus4.host_rvalid),     32'h0);
        chk({tag, "_rd4"},  bus4.host_rdata,           32'h0);
        chk({tag, "_ld4"},  32'(bus4.load_cnt),        32'h0);
        chk({tag, "_st4"},  32'(bus4.store_cnt),       32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        bus1.loaddd_A_a_0_addr   = '0;
        bus1.loaddd_A_b_0_addr   = '0;
        bus1.loaddd_c_a_0_addr   = '0;
        bus1.storeee_A_a_0_addr  = '0;
        bus1.storeee_A_a_0_toMem = '0;
        bus1.host_sel            = 1'b0;
        bus1.host_addr           = '0;
        bus1.host_wdata          = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        host_wr(1'b0, 8'h05, 32'h0000_1234);
        host_wr(1'b1, 8'h03, 32'h0000_0007);

        // Triple kernel read in one cycle
        $display("txn kernel_rd a@05 b@05 c@3");
        bus1.loaddd_A_a_0_en = 1'b1; bus1.loaddd_A_a_0_addr = 8'h05;
        bus1.loaddd_A_b_0_en = 1'b1; bus1.loaddd_A_b_0_addr = 8'h05;
        bus1.loaddd_c_a_0_en = 1'b1; bus1.loaddd_c_a_0_addr = 4'h3;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) idle();
            chk($sformatf("rd3_a1_k%0d", k), bus1.loaddd_A_a_0_fromMem, 32'h1234);
            chk($sformatf("rd3_b1_k%0d", k), bus1.loaddd_A_b_0_fromMem, 32'h1234);
            chk($sformatf("rd3_c1_k%0d", k), bus1.loaddd_c_a_0_fromMem, 32'h7);
            chk($sformatf("rd3_a4_k%0d", k), bus4.loaddd_A_a_0_fromMem, (k >= 4) ? 32'h1234 : 32'h0);
            chk($sformatf("rd3_b4_k%0d", k), bus4.loaddd_A_b_0_fromMem, (k >= 4) ? 32'h1234 : 32'h0);
            chk($sformatf("rd3_c4_k%0d", k), bus4.loaddd_c_a_0_fromMem, (k >= 4) ? 32'h7 : 32'h0);
        end
        chk("rd3_ld1", 32'(bus1.load_cnt), 32'd3);
        chk("rd3_ld4", 32'(bus4.load_cnt), 32'd3);

        // Swapped store with same-cycle a-read (write-first), then b-read next cycle
        $display("txn store toMem=0x2A addr=0x9C + a_rd@2A, then b_rd@2A");
        bus1.storeee_A_a_0_en    = 1'b1;
        bus1.storeee_A_a_0_toMem = 32'h0000_002A;
        bus1.storeee_A_a_0_addr  = 8'h9C;
        bus1.loaddd_A_a_0_en     = 1'b1;
        bus1.loaddd_A_a_0_addr   = 8'h2A;
        for (int k = 1; k <= 6; k++) begin
            tick();
            idle();
            if (k == 1) begin
                bus1.loaddd_A_b_0_en   = 1'b1;
                bus1.loaddd_A_b_0_addr = 8'h2A;
            end
            chk($sformatf("st_a1_k%0d", k), bus1.loaddd_A_a_0_fromMem, 32'h9C);
            chk($sformatf("st_a4_k%0d", k), bus4.loaddd_A_a_0_fromMem, (k >= 4) ? 32'h9C : 32'h1234);
            chk($sformatf("st_b1_k%0d", k), bus1.loaddd_A_b_0_fromMem, (k >= 2) ? 32'h9C : 32'h1234);
            chk($sformatf("st_b4_k%0d", k), bus4.loaddd_A_b_0_fromMem, (k >= 5) ? 32'h9C : 32'h1234);
        end
        chk("st_cnt1", 32'(bus1.store_cnt), 32'd1);
        chk("st_cnt4", 32'(bus4.store_cnt), 32'd1);
        chk("st_ld1",  32'(bus1.load_cnt),  32'd5);

        // Host read blocked by a kernel strobe: ignored, no rvalid
        $display("txn host_rd blocked by kernel c_rd@3");
        bus1.loaddd_c_a_0_en   = 1'b1;
        bus1.loaddd_c_a_0_addr = 4'h3;
        bus1.host_en           = 1'b1;
        bus1.host_we           = 1'b0;
        bus1.host_sel          = 1'b0;
        bus1.host_addr         = 8'h05;
        #1;
        chk("blk_ready1", 32'(bus1.host_ready), 32'd0);
        chk("blk_ready4", 32'(bus4.host_ready), 32'd0);
        tick();
        idle();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("blk_rv1_k%0d", k), 32'(bus1.host_rvalid), 32'd0);
            chk($sformatf("blk_rv4_k%0d", k), 32'(bus4.host_rvalid), 32'd0);
            tick();
        end
        host_rd(1'b0, 8'h05, 32'h1234);
        host_rd(1'b1, 8'hF3, 32'h7);

        // Six cycles of triple reads: 4-bit counter saturates at 15
        $display("txn 6x triple kernel_rd");
        for (int k = 1; k <= 6; k++) begin
            bus1.loaddd_A_a_0_en   = 1'b1;
            bus1.loaddd_A_a_0_addr = (k < 6) ? 8'h05 : 8'h2A;
            bus1.loaddd_A_b_0_en   = 1'b1;
            bus1.loaddd_A_b_0_addr = 8'h05;
            bus1.loaddd_c_a_0_en   = 1'b1;
            bus1.loaddd_c_a_0_addr = 4'h3;
            tick();
        end
        idle();
        chk("sat_ld1", 32'(bus1.load_cnt),  32'd15);
        chk("sat_ld4", 32'(bus4.load_cnt),  32'd24);
        chk("sat_st1", 32'(bus1.store_cnt), 32'd1);
        chk("sat_st4", 32'(bus4.store_cnt), 32'd1);
        chk("sat_a1",  bus1.loaddd_A_a_0_fromMem, 32'h9C);
        chk("sat_rd1", bus1.host_rdata, 32'h7);

        // Reset for two cycles with lat4 reads in flight and a strobe held high
        $display("txn rst 2 cycles mid-traffic");
        rst = 1'b1;
        bus1.loaddd_A_a_0_en   = 1'b1;
        bus1.loaddd_A_a_0_addr = 8'h2A;
        tick();
        chk_reset_state("rst_mid");
        tick();
        rst = 1'b0;
        idle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("post_a1_k%0d", k), bus1.loaddd_A_a_0_fromMem, 32'h0);
            chk($sformatf("post_a4_k%0d", k), bus4.loaddd_A_a_0_fromMem, 32'h0);
            chk($sformatf("post_rv4_k%0d", k), 32'(bus4.host_rvalid), 32'h0);
            chk($sformatf("post_ld4_k%0d", k), 32'(bus4.load_cnt), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
